vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA timing generator; successor to the fixed 800x600 vga_timing block.
//  Produces hcount/vcount, sync, blanking and frame/line strobes for any mode set by parameters.
//  Adds pixel clock-enable, programmable sync polarity and start-of-line/frame strobes.
//  Sits at the head of the video pipeline; downstream draw blocks consume its outputs.
// PARAMETERS
//  CNT_W     11    width of hcount/vcount
//  H_VIS     800   visible pixels per line
//  H_FP      40    horizontal front porch (pixels)
//  H_SYNC    128   horizontal sync width (pixels)
//  H_BP      88    horizontal back porch (pixels)
//  V_VIS     600   visible lines per frame
//  V_FP      1     vertical front porch (lines)
//  V_SYNC    4     vertical sync width (lines)
//  V_BP      23    vertical back porch (lines)
//  HSYNC_POL 1     active level of hsync (1 = active-high)
//  VSYNC_POL 1     active level of vsync
// PORTS
//  clk         in   1      pixel-domain clock (40 MHz for defaults)
//  rst         in   1      synchronous reset, active-high
//  en          in   1      pixel enable; counters advance only when 1
//  hcount      out  CNT_W  horizontal position, 0 .. H_TOT-1
//  vcount      out  CNT_W  vertical position, 0 .. V_TOT-1
//  hsync       out  1      horizontal sync, level per HSYNC_POL
//  vsync       out  1      vertical sync, level per VSYNC_POL
//  hblnk       out  1      1 when hcount >= H_VIS
//  vblnk       out  1      1 when vcount >= V_VIS
//  line_start  out  1      1-cycle strobe: counters show hcount==0 after a wrap
//  frame_start out  1      1-cycle strobe: counters show (0,0) after a wrap
// BEHAVIOUR
//  - H_TOT = H_VIS+H_FP+H_SYNC+H_BP (1056); V_TOT likewise (628). Elaboration error if
//    H_TOT or V_TOT > 2**CNT_W, or any parameter is 0.
//  - Reset (rst=1 at posedge): hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~HSYNC_POL,
//    vsync=~VSYNC_POL, line_start=0, frame_start=0. rst overrides en.
//  - All outputs registered; sync/blank/strobes computed from the next counter values so
//    they are cycle-aligned with hcount/vcount (no skew between any outputs).
//  - en=1: hcount increments; at H_TOT-1 wraps to 0 and vcount increments; vcount at
//    V_TOT-1 with hcount at H_TOT-1 wraps to 0 (both wrap in same cycle).
//  - en=0: counters, sync and blank hold; line_start and frame_start forced 0.
//  - hsync active for H_VIS+H_FP <= hcount < H_VIS+H_FP+H_SYNC (840..967).
//  - vsync active for V_VIS+V_FP <= vcount < V_VIS+V_FP+V_SYNC (601..604); changes
//    together with vcount, i.e. at hcount==0.
//  - line_start=1 in the cycle hcount becomes 0 via wrap; frame_start=1 only when
//    vcount also becomes 0. Neither asserts on exit from reset.
//  - Reset mid-frame: next cycle counters at (0,0), syncs inactive, no strobes.
//  - Counters never exceed H_TOT-1 / V_TOT-1 under any en pattern.
// TESTING
//  1. Reset 3 cycles, en=1: first cycle after reset hcount=1,vcount=0; hsync=vsync=0.
//  2. Free run one line: hblnk rises at hcount=800; hsync high for exactly 128 cycles
//     starting hcount=840; hcount wraps 1055->0 with vcount 0->1 and line_start=1.
//  3. Full frame: vsync high for 4*1056 cycles from vcount=601; frame_start every
//     1056*628=663168 cycles; hcount<1056, vcount<628 asserted every cycle.
//  4. en toggled 1/0 (50% duty): line period doubles to 2112 clk; strobes stay 1 cycle,
//     never asserted while en=0; output values identical to en=1 run per enabled cycle.
//  5. HSYNC_POL=0,VSYNC_POL=0, small mode (H 8/2/3/2, V 4/1/1/1): syncs idle high,
//     low at hcount 10..12 and vcount 5; reset value of both syncs = 1.
//  6. rst asserted at hcount=900 (hsync active): next cycle (0,0), hsync=0, no strobe.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel/line counters with sync, blanking and
// start-of-line/frame strobes, all registered and cycle-aligned with the counters.
module vga_timing_gen #(
    parameter int unsigned CNT_W     = 11,
    parameter int unsigned H_VIS     = 800,
    parameter int unsigned H_FP      = 40,
    parameter int unsigned H_SYNC    = 128,
    parameter int unsigned H_BP      = 88,
    parameter int unsigned V_VIS     = 600,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 4,
    parameter int unsigned V_BP      = 23,
    parameter bit          HSYNC_POL = 1'b1,
    parameter bit          VSYNC_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             line_start,
    output logic             frame_start
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    if (CNT_W == 0 || CNT_W > 31 || H_VIS == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_VIS == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        H_TOT > (32'd1 << CNT_W) || V_TOT > (32'd1 << CNT_W)) begin : g_bad_params
        $error("vga_timing_gen: zero timing parameter or total exceeds counter range");
    end

    // Every boundary is pre-sized to the counter width so comparisons stay width-matched.
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_BLNK_BEG = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_BLNK_BEG = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_VIS + V_FP + V_SYNC);

    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_sync_zone;
    logic             v_sync_zone;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        h_next = hcount;
        v_next = vcount;
        h_wrap = 1'b0;
        v_wrap = 1'b0;
        if (en) begin
            // >= rather than == keeps the counters bounded even from a corrupted state.
            if (hcount >= H_LAST) begin
                h_next = '0;
                h_wrap = 1'b1;
                if (vcount >= V_LAST) begin
                    v_next = '0;
                    v_wrap = 1'b1;
                end else begin
                    v_next = vcount + CNT_W'(1);
                end
            end else begin
                h_next = hcount + CNT_W'(1);
            end
        end
    end

    assign h_sync_zone = (h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END);
    assign v_sync_zone = (v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END);

    // Decodes use the next counter values so every registered output lines up with hcount/vcount.
    // NOTE: sequential state is updated with non-blocking assignments only, so all registers
    // sample the pre-edge values and simulation order cannot create races.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            hblnk       <= 1'b0;
            vblnk       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hcount      <= h_next;
            vcount      <= v_next;
            hsync       <= h_sync_zone ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= v_sync_zone ? VSYNC_POL : ~VSYNC_POL;
            hblnk       <= (h_next >= H_BLNK_BEG);
            vblnk       <= (v_next >= V_BLNK_BEG);
            line_start  <= h_wrap;
            frame_start <= v_wrap;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default 800x600 mode and a tiny inverted-polarity
// mode run side by side against a position-arithmetic reference model.
module tb_vga_timing_gen;

    typedef struct packed {
        int   h_vis, h_fp, h_sync, h_bp;
        int   v_vis, v_fp, v_sync, v_bp;
        logic hpol, vpol;
    } mode_t;

    logic        clk = 1'b0;
    logic        rst_a, en_a, rst_b, en_b;
    logic [10:0] hcount_a, vcount_a;
    logic [4:0]  hcount_b, vcount_b;
    logic        hsync_a, vsync_a, hblnk_a, vblnk_a, line_start_a, frame_start_a;
    logic        hsync_b, vsync_b, hblnk_b, vblnk_b, line_start_b, frame_start_b;

    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    mode_t mode_a, mode_b;
    int    n_a = 0, n_b = 0;      // enabled pixel steps since the last reset
    bit    st_a = 0, st_b = 0;    // a pixel step happened in the latest cycle

    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk(clk), .rst(rst_a), .en(en_a),
        .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
        .hblnk(hblnk_a), .vblnk(vblnk_a), .line_start(line_start_a), .frame_start(frame_start_a)
    );

    vga_timing_gen #(
        .CNT_W(5), .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VIS(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) u_b (
        .clk(clk), .rst(rst_b), .en(en_b),
        .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
        .hblnk(hblnk_b), .vblnk(vblnk_b), .line_start(line_start_b), .frame_start(frame_start_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected outputs follow directly from the raster position n = steps since reset.
    task automatic check_mode(input string pfx, input mode_t m, input int n, input bit st,
                              input logic [31:0] hc, input logic [31:0] vc,
                              input logic hs, input logic vs, input logic hb, input logic vb,
                              input logic ls, input logic fs);
        int h_tot, v_tot, h, v;
        logic e_hs, e_vs;
        h_tot = m.h_vis + m.h_fp + m.h_sync + m.h_bp;
        v_tot = m.v_vis + m.v_fp + m.v_sync + m.v_bp;
        h = n % h_tot;
        v = (n / h_tot) % v_tot;
        e_hs = (h >= m.h_vis + m.h_fp && h < m.h_vis + m.h_fp + m.h_sync) ? m.hpol : ~m.hpol;
        e_vs = (v >= m.v_vis + m.v_fp && v < m.v_vis + m.v_fp + m.v_sync) ? m.vpol : ~m.vpol;
        check({pfx, ".hcount"}, hc, h);
        check({pfx, ".vcount"}, vc, v);
        check({pfx, ".hsync"}, 32'(hs), 32'(e_hs));
        check({pfx, ".vsync"}, 32'(vs), 32'(e_vs));
        check({pfx, ".hblnk"}, 32'(hb), 32'(h >= m.h_vis));
        check({pfx, ".vblnk"}, 32'(vb), 32'(v >= m.v_vis));
        check({pfx, ".line_start"}, 32'(ls), 32'(st && h == 0));
        check({pfx, ".frame_start"}, 32'(fs), 32'(st && h == 0 && v == 0));
        check({pfx, ".h_in_range"}, 32'(hc < 32'(h_tot)), 1);
        check({pfx, ".v_in_range"}, 32'(vc < 32'(v_tot)), 1);
    endtask

    // Drive one cycle of inputs (away from the edge), then check both DUTs 1 time unit after it.
    task automatic cycle(input bit ea, input bit ra, input bit eb, input bit rb);
        en_a = ea; rst_a = ra; en_b = eb; rst_b = rb;
        @(posedge clk);
        #1;
        cyc++;
        if (ra) begin n_a = 0; st_a = 0; end
        else if (ea) begin n_a++; st_a = 1; end
        else st_a = 0;
        if (rb) begin n_b = 0; st_b = 0; end
        else if (eb) begin n_b++; st_b = 1; end
        else st_b = 0;
        check_mode("a", mode_a, n_a, st_a, 32'(hcount_a), 32'(vcount_a), hsync_a, vsync_a,
                   hblnk_a, vblnk_a, line_start_a, frame_start_a);
        check_mode("b", mode_b, n_b, st_b, 32'(hcount_b), 32'(vcount_b), hsync_b, vsync_b,
                   hblnk_b, vblnk_b, line_start_b, frame_start_b);
    endtask

    initial begin
        int hs_high, fs_last, ls_prev, lines;
        mode_a = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};
        mode_b = '{8, 2, 3, 2, 4, 1, 1, 1, 1'b0, 1'b0};
        rst_a = 1'b1; en_a = 1'b1; rst_b = 1'b1; en_b = 1'b1;

        // Reset held 3 cycles with en=1: rst must win, syncs sit at their idle levels.
        repeat (3) cycle(1, 1, 1, 1);
        check("b.reset_hsync_idle", 32'(hsync_b), 1);
        check("b.reset_vsync_idle", 32'(vsync_b), 1);

        cycle(1, 0, 1, 0);
        check("a.first_hcount", 32'(hcount_a), 1);
        check("a.first_vcount", 32'(vcount_a), 0);
        check("a.first_line_start", 32'(line_start_a), 0);

        // One full default line; the small mode meanwhile runs ~10 frames at en=1.
        hs_high = 0;
        fs_last = -1;
        for (int i = 0; i < 1099; i++) begin
            cycle(1, 0, 1, 0);
            if (n_a < 1056 && hsync_a) hs_high++;
            if (n_a == 1056) begin
                check("a.wrap_hcount", 32'(hcount_a), 0);
                check("a.wrap_vcount", 32'(vcount_a), 1);
                check("a.wrap_line_start", 32'(line_start_a), 1);
            end
            if (frame_start_b) begin
                if (fs_last >= 0) check("b.frame_period", cyc - fs_last, 105);
                fs_last = cyc;
            end
        end
        check("a.hsync_width", hs_high, 128);

        // Walk to hcount 900 (inside hsync), then reset mid-line.
        for (int i = 0; i < 2000 && (n_a % 1056) != 900; i++) cycle(1, 0, 1'($urandom), 0);
        check("a.pre_reset_hcount", 32'(hcount_a), 900);
        check("a.pre_reset_hsync", 32'(hsync_a), 1);
        cycle(1, 1, 1'($urandom), 0);
        check("a.midreset_hcount", 32'(hcount_a), 0);
        check("a.midreset_vcount", 32'(vcount_a), 0);
        check("a.midreset_hsync", 32'(hsync_a), 0);
        check("a.midreset_strobe", 32'(line_start_a | frame_start_a), 0);

        // 50% enable duty: line period stretches to 2112 clocks.
        ls_prev = -1;
        lines = 0;
        for (int i = 0; i < 4300; i++) begin
            cycle(i % 2 == 0, 0, 1'($urandom), ($urandom_range(0, 96) == 0));
            if (line_start_a) begin
                lines++;
                if (ls_prev >= 0) check("a.toggle_line_period", cyc - ls_prev, 2112);
                ls_prev = cyc;
            end
        end
        check("a.toggle_lines", lines, 2);

        // Random enable pattern with occasional resets on both instances.
        for (int i = 0; i < 2000; i++)
            cycle(1'($urandom), ($urandom_range(0, 499) == 0),
                  1'($urandom), ($urandom_range(0, 199) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
